// File: rtl/riscv_core_scoreboard_hazard_unit.sv
// riscv_core_scoreboard_hazard_unit: forwarding, load-use/scoreboard/structural stalls, flush control and exception drain for RV64IMAC.
// Ports:
//   i_hazard_unit_clk/rst            clock, synchronous active-high reset
//   i_hazard_unit_rs*_id/rd_id       ID operands/destination, long_op_id marks a long-latency op in ID
//   i_hazard_unit_rs*_ex/rd_*        pipeline register ids with regwrite_mem/wb and resultsrc_ex
//   i_hazard_unit_long_issue_ex      long op leaves EX, long_done/long_rd its completion on the side write port
//   i_hazard_unit_*cache_stall       cache miss stalls, csr_flush per-stage flush requests
//   i_hazard_unit_illegal_instr etc  exception sources
//   o_hazard_unit_forward*_ex        operand mux selects, stall_*/flush_* stage controls
//   o_hazard_unit_exception          trap-take pulse, sb_busy/outstanding scoreboard state, timeout sticky flag
module riscv_core_scoreboard_hazard_unit #(
   parameter int NREG = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STALL_TIMEOUT = 1024,
   localparam int REG_W = $clog2(NREG),
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1),
   localparam int TMO_W = $clog2(STALL_TIMEOUT + 1)
) (
   input  logic             i_hazard_unit_clk,
   input  logic             i_hazard_unit_rst,
   input  logic [REG_W-1:0] i_hazard_unit_rs1_id,
   input  logic [REG_W-1:0] i_hazard_unit_rs2_id,
   input  logic [REG_W-1:0] i_hazard_unit_rd_id,
   input  logic             i_hazard_unit_long_op_id,
   input  logic [REG_W-1:0] i_hazard_unit_rs1_ex,
   input  logic [REG_W-1:0] i_hazard_unit_rs2_ex,
   input  logic [REG_W-1:0] i_hazard_unit_rd_ex,
   input  logic [REG_W-1:0] i_hazard_unit_rd_mem,
   input  logic [REG_W-1:0] i_hazard_unit_rd_wb,
   input  logic             i_hazard_unit_regwrite_mem,
   input  logic             i_hazard_unit_regwrite_wb,
   input  logic [1:0]       i_hazard_unit_resultsrc_ex,
   input  logic             i_hazard_unit_pcsrc_ex,
   input  logic             i_hazard_unit_long_issue_ex,
   input  logic             i_hazard_unit_long_done,
   input  logic [REG_W-1:0] i_hazard_unit_long_rd,
   input  logic             i_hazard_unit_icache_stall,
   input  logic             i_hazard_unit_dcache_stall,
   input  logic [3:0]       i_hazard_unit_csr_flush,
   input  logic             i_hazard_unit_illegal_instr,
   input  logic             i_hazard_unit_mdivby0,
   input  logic             i_hazard_unit_mof,
   output logic [1:0]       o_hazard_unit_forwarda_ex,
   output logic [1:0]       o_hazard_unit_forwardb_ex,
   output logic             o_hazard_unit_stall_if,
   output logic             o_hazard_unit_stall_id,
   output logic             o_hazard_unit_stall_ex,
   output logic             o_hazard_unit_stall_mem,
   output logic             o_hazard_unit_stall_wb,
   output logic             o_hazard_unit_flush_if,
   output logic             o_hazard_unit_flush_id,
   output logic             o_hazard_unit_flush_ex,
   output logic             o_hazard_unit_flush_mem,
   output logic             o_hazard_unit_exception,
   output logic [NREG-1:0]  o_hazard_unit_sb_busy,
   output logic [CNT_W-1:0] o_hazard_unit_outstanding,
   output logic             o_hazard_unit_timeout
);
   typedef enum logic [1:0] {IDLE, DRAIN, TRAP} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(STALL_TIMEOUT);
   state_t state, state_nxt;
   logic [NREG-1:0] set_v, clr_v, busy_eff;
   logic [TMO_W-1:0] tmo_cnt;
   logic [CNT_W:0] load;
   logic issue, done_ok, lw, sb, full, hold, drain;
   function automatic logic [1:0] fwd(input logic [REG_W-1:0] rs, rd_mem, long_rd, rd_wb,
                                      input logic we_mem, done, we_wb);
      return (rs == '0) ? 2'b00 : (we_mem && rd_mem == rs) ? 2'b10 :
             (done && long_rd == rs) ? 2'b11 : (we_wb && rd_wb == rs) ? 2'b01 : 2'b00;
   endfunction
   always_comb begin
      issue = i_hazard_unit_long_issue_ex && !i_hazard_unit_dcache_stall;
      set_v = (issue && i_hazard_unit_rd_ex != '0) ? NREG'(1) << i_hazard_unit_rd_ex : '0;
      clr_v = i_hazard_unit_long_done ? NREG'(1) << i_hazard_unit_long_rd : '0;
      // a register completing this cycle is already readable via the long-result bus
      busy_eff = o_hazard_unit_sb_busy & ~clr_v;
      done_ok = i_hazard_unit_long_done && o_hazard_unit_outstanding != '0;
      // projected occupancy: a completion this cycle frees a slot immediately
      load = {1'b0, o_hazard_unit_outstanding} + (CNT_W + 1)'(i_hazard_unit_long_issue_ex) - (CNT_W + 1)'(done_ok);
      lw = i_hazard_unit_resultsrc_ex == 2'b01 && i_hazard_unit_rd_ex != '0 &&
           (i_hazard_unit_rd_ex == i_hazard_unit_rs1_id || i_hazard_unit_rd_ex == i_hazard_unit_rs2_id);
      sb = busy_eff[i_hazard_unit_rs1_id] | busy_eff[i_hazard_unit_rs2_id] | busy_eff[i_hazard_unit_rd_id];
      full = i_hazard_unit_long_op_id && load >= {1'b0, CNT_MAX};
      hold = lw | sb | full;
      drain = state == DRAIN;
      state_nxt = (state == IDLE) ?
                     ((i_hazard_unit_illegal_instr | i_hazard_unit_mdivby0 | i_hazard_unit_mof) ? DRAIN : IDLE) :
                  (state == DRAIN) ?
                     ((o_hazard_unit_outstanding == '0 && !i_hazard_unit_long_issue_ex && !i_hazard_unit_dcache_stall) ? TRAP : DRAIN) :
                  IDLE;
   end
   assign o_hazard_unit_forwarda_ex = fwd(i_hazard_unit_rs1_ex, i_hazard_unit_rd_mem, i_hazard_unit_long_rd, i_hazard_unit_rd_wb,
                                          i_hazard_unit_regwrite_mem, i_hazard_unit_long_done, i_hazard_unit_regwrite_wb);
   assign o_hazard_unit_forwardb_ex = fwd(i_hazard_unit_rs2_ex, i_hazard_unit_rd_mem, i_hazard_unit_long_rd, i_hazard_unit_rd_wb,
                                          i_hazard_unit_regwrite_mem, i_hazard_unit_long_done, i_hazard_unit_regwrite_wb);
   assign o_hazard_unit_stall_if  = hold | i_hazard_unit_icache_stall | i_hazard_unit_dcache_stall | drain;
   assign o_hazard_unit_stall_id  = hold | i_hazard_unit_dcache_stall;
   assign o_hazard_unit_stall_ex  = i_hazard_unit_dcache_stall;
   assign o_hazard_unit_stall_mem = i_hazard_unit_dcache_stall;
   assign o_hazard_unit_stall_wb  = 1'b0;
   assign o_hazard_unit_flush_if  = i_hazard_unit_csr_flush[0] | drain;
   assign o_hazard_unit_flush_id  = i_hazard_unit_pcsrc_ex | i_hazard_unit_csr_flush[1] | drain;
   assign o_hazard_unit_flush_ex  = hold | i_hazard_unit_pcsrc_ex | i_hazard_unit_csr_flush[2] | drain;
   assign o_hazard_unit_flush_mem = i_hazard_unit_csr_flush[3];
   assign o_hazard_unit_exception = state == TRAP;
   always_ff @(posedge i_hazard_unit_clk) begin
      if (i_hazard_unit_rst) begin
         o_hazard_unit_sb_busy <= '0;
         o_hazard_unit_outstanding <= '0;
         state <= IDLE;
         tmo_cnt <= '0;
         o_hazard_unit_timeout <= 1'b0;
      end else begin
         o_hazard_unit_sb_busy <= ((o_hazard_unit_sb_busy & ~clr_v) | set_v) & ~NREG'(1);
         o_hazard_unit_outstanding <= (issue && done_ok) ? o_hazard_unit_outstanding :
                                      (issue && o_hazard_unit_outstanding != CNT_MAX) ? o_hazard_unit_outstanding + 1'b1 :
                                      done_ok ? o_hazard_unit_outstanding - 1'b1 : o_hazard_unit_outstanding;
         state <= state_nxt;
         tmo_cnt <= !o_hazard_unit_stall_if ? '0 : (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
         o_hazard_unit_timeout <= o_hazard_unit_timeout | (o_hazard_unit_stall_if && tmo_cnt >= TMO_MAX - 1'b1);
      end
   end
endmodule
